// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on operand magnitudes,
// sign fix-up in a final cycle, cancellable from the exception flush.
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | shift-add / restoring-divide iterations, counter counts down to 0
// FIX   | sign correction, HI/LO written
// DONE  | ready_o asserted, result valid
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q, neg_q, sign_a_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dz_q;

  logic               is_signed, div_zero, accept;
  logic [WIDTH-1:0]   mag_a, mag_b, addend;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    is_signed = ~op_i[0];
    div_zero  = op_i[1] & (b_i == '0);
    accept    = start_i & ~cancel_i & ((state_q == IDLE) | (state_q == DONE));
    mag_a     = (is_signed & a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b     = (is_signed & b_i[WIDTH-1]) ? -b_i : b_i;
    busy_o    = ~rst & ((state_q == CALC) | (state_q == FIX) | (accept & ~div_zero));
  end

  // acc_q holds {partial product, multiplier} or {remainder, quotient/dividend}
  always_comb begin
    addend    = acc_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    if (is_div_q) begin
      fix_lo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_hi = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      dz_q <= 1'b0;
      if (cancel_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start_i) begin
              is_div_q <= op_i[1];
              neg_q    <= is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              sign_a_q <= is_signed & a_i[WIDTH-1];
              opnd_q   <= op_i[1] ? mag_b : mag_a;
              acc_q    <= {{WIDTH{1'b0}}, (op_i[1] ? mag_a : mag_b)};
              if (div_zero) begin
                state_q <= DONE;
                hi_q    <= a_i;
                lo_q    <= '1;
                dz_q    <= 1'b1;
              end else begin
                state_q <= CALC;
                cnt_q   <= CW'(WIDTH - 1);
              end
            end else begin
              state_q <= IDLE;
            end
          end
          CALC: begin
            acc_q <= acc_d;
            if (cnt_q == '0) state_q <= FIX;
            else             cnt_q   <= cnt_q - CW'(1);
          end
          FIX: begin
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
            state_q <= DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready_o    = (state_q == DONE);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: WIDTH=32 and WIDTH=8 instances, directed table,
// cancel/back-to-back/reset sequences and randomized ops against an arithmetic model.
module tb_muldiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        s32, c32, busy32, rdy32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        s8, c8, busy8, rdy8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(s32), .op_i(op32), .a_i(a32), .b_i(b32),
    .cancel_i(c32), .busy_o(busy32), .ready_o(rdy32), .hi_o(hi32), .lo_o(lo32),
    .div_zero_o(dz32));

  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(s8), .op_i(op8), .a_i(a8), .b_i(b8),
    .cancel_i(c8), .busy_o(busy8), .ready_o(rdy8), .hi_o(hi8), .lo_o(lo8),
    .div_zero_o(dz8));

  int checks = 0;
  int failures = 0;
  logic [31:0] last_hi32 = 0, last_lo32 = 0;

  typedef struct {
    bit          w8;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic st, input logic cn, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin s8 = st; c8 = cn; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin s32 = st; c32 = cn; op32 = op; a32 = a; b32 = b; end
  endtask

  task automatic sample(input bit w8, output logic bz, output logic rd, output logic dz,
                        output logic [31:0] hi, output logic [31:0] lo);
    if (w8) begin bz = busy8; rd = rdy8; dz = dz8; hi = {24'b0, hi8}; lo = {24'b0, lo8}; end
    else    begin bz = busy32; rd = rdy32; dz = dz32; hi = hi32; lo = lo32; end
  endtask

  function automatic longint sext(input logic [31:0] x, input int w);
    longint v;
    v = longint'({32'b0, x} & ((64'd1 << w) - 64'd1));
    if (x[w-1]) v = v - longint'(64'd1 << w);
    return v;
  endfunction

  // Reference: plain integer arithmetic on w-bit operands
  task automatic model(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, minv;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, a} & mask;
    ub = {32'b0, b} & mask;
    sa = sext(a, w);
    sb = sext(b, w);
    minv = -(longint'(1) << (w - 1));
    dz = 1'b0;
    p = 64'd0;
    if (op[1] && ub == 64'd0) begin
      hi = 32'(ua); lo = mask[31:0]; dz = 1'b1;
    end else begin
      case (op)
        2'b00: begin p = 64'(sa * sb); hi = 32'((p >> w) & mask); lo = 32'(p & mask); end
        2'b01: begin p = ua * ub;      hi = 32'((p >> w) & mask); lo = 32'(p & mask); end
        2'b10: begin
          if (sa == minv && sb == -1) begin lo = 32'(ua); hi = 32'd0; end
          else begin lo = 32'(64'(sa / sb) & mask); hi = 32'(64'(sa % sb) & mask); end
        end
        default: begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      endcase
    end
  endtask

  task automatic do_op(input bit w8, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input bit poke, input string tag);
    int w, lat, kr;
    bit dzc, busy_ok;
    logic bz, rd, dz;
    logic [31:0] hi, lo, mask;
    w = w8 ? 8 : 32;
    mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
    dzc = op[1] && ((b & mask) == 32'd0);
    lat = dzc ? 1 : w + 2;
    kr = 0;
    busy_ok = 1'b1;
    drive(w8, 1'b1, 1'b0, op, a, b);
    #1;
    sample(w8, bz, rd, dz, hi, lo);
    chk({tag, "_busy_accept"}, bz, !dzc);
    for (int k = 1; k <= w + 6 && kr == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1 || (poke && k == 4)) drive(w8, 1'b0, 1'b0, 2'($urandom), $urandom, $urandom);
      else if (poke && k == 3)        drive(w8, 1'b1, 1'b0, 2'($urandom), $urandom, $urandom);
      #1;
      sample(w8, bz, rd, dz, hi, lo);
      if (bz !== (!rd && !dzc)) busy_ok = 1'b0;
      if (rd === 1'b1) kr = k;
    end
    chk({tag, "_latency"}, kr, lat);
    chk({tag, "_busy_profile"}, busy_ok, 1);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_div_zero"}, dz, edz);
    @(posedge clk); #2;
    sample(w8, bz, rd, dz, hi, lo);
    chk({tag, "_ready_single"}, rd, 0);
    chk({tag, "_dz_after"}, dz, 0);
    chk({tag, "_hi_held"}, hi, ehi);
    chk({tag, "_lo_held"}, lo, elo);
    if (!w8) begin last_hi32 = ehi; last_lo32 = elo; end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bz, rd, dz, edz;
    logic [31:0] hi, lo, ehi, elo;
    bit w8, flag;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [1:0]  bop[3];
    logic [31:0] ba[3], bb[3], bh[3], bl[3];

    tbl[0] = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    tbl[1] = '{1'b0, 2'd1, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 1'b0};
    tbl[2] = '{1'b0, 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
    tbl[3] = '{1'b0, 2'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[4] = '{1'b0, 2'd3, 32'h7,         32'h2,         32'h1,         32'h3,         1'b0};
    tbl[5] = '{1'b0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    tbl[6] = '{1'b0, 2'd3, 32'h5,         32'h0,         32'h5,         32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{1'b1, 2'd2, 32'h80,        32'hFF,        32'h0,         32'h80,        1'b0};
    tbl[8] = '{1'b1, 2'd0, 32'hFF,        32'h2,         32'hFF,        32'hFE,        1'b0};
    tbl[9] = '{1'b1, 2'd2, 32'h80,        32'h0,         32'h80,        32'hFF,        1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) begin
      sample(i == 1, bz, rd, dz, hi, lo);
      chk("reset_busy", bz, 0);
      chk("reset_ready", rd, 0);
      chk("reset_dz", dz, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
    end

    foreach (tbl[i])
      do_op(tbl[i].w8, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, 1'b0,
            $sformatf("vec%0d", i));

    // cancel with a simultaneous start in cycle 10 of a DIV
    flag = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'b10, 32'd100, 32'd7);
    #1;
    chk("cancel_busy_accept", busy32, 1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1)  drive(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
      if (k == 10) drive(1'b0, 1'b1, 1'b1, 2'b01, 32'd3, 32'd4);
      #1;
      if (rdy32 !== 1'b0) flag = 1'b1;
      if (k == 10) chk("cancel_busy_calc", busy32, 1);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    #1;
    chk("cancel_no_ready_early", flag, 0);
    chk("cancel_ready", rdy32, 0);
    chk("cancel_idle_busy", busy32, 0);
    chk("cancel_hi_kept", hi32, last_hi32);
    chk("cancel_lo_kept", lo32, last_lo32);
    do_op(1'b0, 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, "after_cancel");

    // back-to-back in DONE on the 8-bit unit
    for (int i = 0; i < 3; i++) begin
      bop[i] = 2'($urandom_range(0, 3));
      ba[i]  = $urandom;
      bb[i]  = $urandom | 32'h1;
      model(8, bop[i], ba[i], bb[i], bh[i], bl[i], edz);
    end
    flag = 1'b1;
    drive(1'b1, 1'b1, 1'b0, bop[0], ba[0], bb[0]);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k % 10 == 1) drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      #1;
      if (rdy8 !== (k % 10 == 0)) flag = 1'b0;
      if (k % 10 == 0) begin
        chk($sformatf("b2b%0d_hi", k / 10), {24'b0, hi8}, bh[k/10-1]);
        chk($sformatf("b2b%0d_lo", k / 10), {24'b0, lo8}, bl[k/10-1]);
        if (k < 30) begin
          drive(1'b1, 1'b1, 1'b0, bop[k/10], ba[k/10], bb[k/10]);
          #1;
          chk("b2b_busy_accept", busy8, 1);
        end
      end
    end
    chk("b2b_pulse_spacing", flag, 1);
    @(posedge clk); #1;

    // reset in cycle 5 of an 8-bit MULT
    drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h7F, 32'h7F);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) drive(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
      if (k == 5) begin rst = 1'b1; drive(1'b1, 1'b1, 1'b1, 2'b01, 32'd3, 32'd3); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    #1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_ready", rdy8, 0);
    chk("midrst_dz", dz8, 0);
    chk("midrst_hi", hi8, 0);
    chk("midrst_lo", lo8, 0);
    model(8, 2'b00, 32'h7F, 32'h81, ehi, elo, edz);
    do_op(1'b1, 2'b00, 32'h7F, 32'h81, ehi, elo, edz, 1'b0, "after_rst");

    for (int i = 0; i < 220; i++) begin
      w8 = (i >= 150);
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = w8 ? 32'h80 : 32'h8000_0000;
        default: ;
      endcase
      model(w8 ? 8 : 32, op, a, b, ehi, elo, edz);
      do_op(w8, op, a, b, ehi, elo, edz, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
